// File: rtl/seq_calc_core.sv
// seq_calc_core: multi-cycle calculator execution core.
// One decoded instruction is accepted per valid/ready handshake. Both operands
// come from the internal register file and the result is written back to rd.
// MUL runs as a shift-add sequencer and DIV/MOD as a restoring divider, each
// taking WIDTH iteration cycles. A one-cycle done pulse reports completion.
module seq_calc_core #(
  parameter int WIDTH = 16,
  parameter int REGS  = 16,
  localparam int RBITS = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [RBITS-1:0] rd,
  input  logic [RBITS-1:0] rs,
  input  logic [WIDTH-1:0] imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             neg,
  output logic             ovf,
  output logic             dbz,
  output logic             illegal,
  output logic             busy,
  input  logic [RBITS-1:0] dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_MOD = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] regs [REGS];
  logic [WIDTH-1:0] rd_val, rs_val;

  logic [2:0]       op_q;
  logic [RBITS-1:0] rd_q;
  logic [WIDTH-1:0] a_q, b_q, imm_q;

  // Sequencer: upper half is the MUL accumulator / DIV remainder,
  // lower half is the MUL multiplier / DIV quotient.
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [CNTW-1:0]    cnt_q;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic               seq_op;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] fin_result;
  logic             fin_neg, fin_ovf, fin_dbz, fin_ill, fin_we;
  logic             enter_done;

  logic [WIDTH-1:0] result_q;
  logic             neg_q, ovf_q, dbz_q, ill_q;

  assign result  = result_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;
  assign dbz     = dbz_q;
  assign illegal = ill_q;

  assign enter_done = (state_d == S_DONE);
  assign seq_op     = (op_q == OP_MUL) ||
                      (((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q != '0));

  // Register file reads; register 0 is hard-wired to zero on every port
  always_comb begin
    rd_val   = '0;
    rs_val   = '0;
    dbg_data = '0;
    if (rd != '0)       rd_val   = regs[rd];
    if (rs != '0)       rs_val   = regs[rs];
    if (dbg_addr != '0) dbg_data = regs[dbg_addr];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state and handshake/status outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = seq_op ? S_ITER : S_DONE;
      S_ITER: if (cnt_q == CNTW'(1)) state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One sequencer step: shift-add for MUL, restoring subtract for DIV/MOD
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = ~div_diff[WIDTH];
    if (op_q == OP_MUL)
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (div_ge)
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Result, flags and write enable presented on the edge that enters DONE
  always_comb begin
    fin_result = result_q;
    fin_neg    = 1'b0;
    fin_ovf    = 1'b0;
    fin_dbz    = 1'b0;
    fin_ill    = 1'b0;
    fin_we     = 1'b0;
    add_sum    = {1'b0, a_q} + {1'b0, b_q};
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_ADD: begin
          fin_result = add_sum[WIDTH-1:0];
          fin_ovf    = add_sum[WIDTH];
          fin_we     = 1'b1;
        end
        OP_SUB: begin
          if (b_q > a_q) begin
            fin_result = b_q - a_q;
            fin_neg    = 1'b1;
          end else begin
            fin_result = a_q - b_q;
          end
          fin_we = 1'b1;
        end
        OP_LDI: begin
          fin_result = imm_q;
          fin_we     = 1'b1;
        end
        OP_DIV, OP_MOD: begin
          if (b_q == '0) begin
            fin_result = '0;
            fin_dbz    = 1'b1;
            fin_we     = 1'b1;
          end
        end
        OP_MUL: ;
        default: fin_ill = 1'b1;
      endcase
    end else if (state_q == S_ITER) begin
      case (op_q)
        OP_MUL: begin
          fin_result = acc_step[WIDTH-1:0];
          fin_ovf    = |acc_step[2*WIDTH-1:WIDTH];
          fin_we     = 1'b1;
        end
        OP_DIV: begin
          fin_result = acc_step[WIDTH-1:0];
          fin_we     = 1'b1;
        end
        OP_MOD: begin
          fin_result = acc_step[2*WIDTH-1:WIDTH];
          fin_we     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Instruction capture: operands are snapshotted at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      rd_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
    end else if (in_valid && in_ready) begin
      op_q  <= op;
      rd_q  <= rd;
      a_q   <= rd_val;
      b_q   <= rs_val;
      imm_q <= imm;
    end
  end

  // Iterative sequencer: loaded in EXEC, stepped once per ITER cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if ((state_q == S_EXEC) && (state_d == S_ITER)) begin
      acc_q <= (op_q == OP_MUL) ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{1'b0}}, a_q};
      cnt_q <= CNTW'(WIDTH);
    end else if (state_q == S_ITER) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CNTW'(1);
    end
  end

  // Register file write-back on the edge entering DONE; rd==0 is discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (enter_done && fin_we && (rd_q != '0)) begin
      regs[rd_q] <= fin_result;
    end
  end

  // Result and flags update together on every DONE and hold in between
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else if (enter_done) begin
      result_q <= fin_result;
      neg_q    <= fin_neg;
      ovf_q    <= fin_ovf;
      dbz_q    <= fin_dbz;
      ill_q    <= fin_ill;
    end
  end

endmodule
